// File: rtl/nand_cpu_pkg.sv
// nand_cpu_pkg: shared writeback types and register-file address widths.
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
package nand_cpu_pkg;
  localparam int WB_NUM_PORTS = 2;
  localparam int D_AW = $clog2(`NUM_D_REG);
  localparam int S_AW = $clog2(`NUM_S_REG);
  typedef struct packed {
    logic            d_valid;
    logic [D_AW-1:0] d_addr;
    logic [15:0]     d_data;
    logic            s_valid;
    logic [S_AW-1:0] s_addr;
    logic            s_data;
  } wb_req_t;
endpackage

// File: rtl/regfile_write_ifc.sv
// regfile_write_ifc: write/forward ports for the data and status register files.
interface regfile_d_write_ifc;
  logic                          valid;
  logic [nand_cpu_pkg::D_AW-1:0] addr;
  logic [15:0]                   data;
  modport drv (output valid, addr, data);
  modport rcv (input valid, addr, data);
endinterface

interface regfile_s_write_ifc;
  logic                          valid;
  logic [nand_cpu_pkg::S_AW-1:0] addr;
  logic                          data;
  modport drv (output valid, addr, data);
  modport rcv (input valid, addr, data);
endinterface

// File: rtl/wb_pick_first.sv
// wb_pick_first: lowest set bit of i_hi, else first set bit of i_req scanning from i_start.
module wb_pick_first #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_hi,
  input  logic [$clog2(N)-1:0] i_start,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_j;
  always_comb begin
    o_idx = '0;
    w_j = '0;
    o_found = |i_req;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_start) + k) % N);
      if (i_req[w_j]) o_idx = w_j;
    end
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'(k);
      if (i_hi[w_j]) o_idx = w_j;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-port writeback arbiter with starvation promotion.
// Define WB_ARB_RR_EN for a round-robin base policy; otherwise fixed priority.
module wb_arbiter
  import nand_cpu_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_d_valid,
  input  logic [NUM_REQ-1:0][D_AW-1:0]   req_d_addr,
  input  logic [NUM_REQ-1:0][15:0]       req_d_data,
  input  logic [NUM_REQ-1:0]             req_s_valid,
  input  logic [NUM_REQ-1:0][S_AW-1:0]   req_s_addr,
  input  logic [NUM_REQ-1:0]             req_s_data,
  regfile_d_write_ifc.drv                e_a_dfw,
  regfile_d_write_ifc.drv                e_c_dfw,
  regfile_s_write_ifc.drv                e_a_sfw,
  regfile_s_write_ifc.drv                e_c_sfw
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [NUM_REQ-1:0][CW-1:0] r_cnt;
  logic [NUM_REQ-1:0]         w_hi, w_a_oh, w_c_oh, w_gnt;
  logic [IW-1:0]              w_start, w_a_idx, w_c_idx;
  logic                       w_a_found, w_c_found;
  logic [WB_NUM_PORTS-1:0]    w_ok;
  wb_req_t                    r_a, r_c, w_a_req, w_c_req;
  always_comb
    for (int i = 0; i < NUM_REQ; i++) w_hi[i] = req_valid[i] && r_cnt[i] == CW'(STARVE_LIMIT);
  wb_pick_first #(.N(NUM_REQ)) u_pick_a (
    .i_req(req_valid), .i_hi(w_hi), .i_start(w_start), .o_idx(w_a_idx), .o_found(w_a_found)
  );
  assign w_a_oh = w_a_found ? NUM_REQ'(1) << w_a_idx : '0;
  wb_pick_first #(.N(NUM_REQ)) u_pick_c (
    .i_req(req_valid & ~w_a_oh), .i_hi(w_hi & ~w_a_oh), .i_start(w_start),
    .o_idx(w_c_idx), .o_found(w_c_found)
  );
  assign w_c_oh    = w_c_found ? NUM_REQ'(1) << w_c_idx : '0;
  assign w_ok      = {w_c_found, w_a_found} & {WB_NUM_PORTS{!flush}};
  assign w_gnt     = (n_rst && !flush) ? (w_a_oh | w_c_oh) : '0;
  assign req_ready = w_gnt;
  assign w_a_req = '{d_valid: req_d_valid[w_a_idx] && w_ok[0], d_addr: req_d_addr[w_a_idx],
                     d_data: req_d_data[w_a_idx], s_valid: req_s_valid[w_a_idx] && w_ok[0],
                     s_addr: req_s_addr[w_a_idx], s_data: req_s_data[w_a_idx]};
  assign w_c_req = '{d_valid: req_d_valid[w_c_idx] && w_ok[1], d_addr: req_d_addr[w_c_idx],
                     d_data: req_d_data[w_c_idx], s_valid: req_s_valid[w_c_idx] && w_ok[1],
                     s_addr: req_s_addr[w_c_idx], s_data: req_s_data[w_c_idx]};
`ifdef WB_ARB_RR_EN
  logic [IW-1:0] r_ptr, w_last;
  assign w_start = r_ptr;
  assign w_last  = w_c_found ? w_c_idx : w_a_idx;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_ptr <= '0;
    else if (w_ok[0]) r_ptr <= (w_last == IW'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
`else
  assign w_start = '0;
`endif
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_a   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else begin
      r_a <= w_a_req;
      r_c <= w_c_req;
      for (int i = 0; i < NUM_REQ; i++)
        r_cnt[i] <= (flush || !req_valid[i] || w_gnt[i]) ? '0 :
                    (r_cnt[i] == CW'(STARVE_LIMIT)) ? r_cnt[i] : r_cnt[i] + 1'b1;
    end
  assign e_a_dfw.valid = r_a.d_valid;
  assign e_a_dfw.addr  = r_a.d_addr;
  assign e_a_dfw.data  = r_a.d_data;
  assign e_c_dfw.valid = r_c.d_valid;
  assign e_c_dfw.addr  = r_c.d_addr;
  assign e_c_dfw.data  = r_c.d_data;
  assign e_a_sfw.valid = r_a.s_valid;
  assign e_a_sfw.addr  = r_a.s_addr;
  assign e_a_sfw.data  = r_a.s_data;
  assign e_c_sfw.valid = r_c.s_valid;
  assign e_c_sfw.addr  = r_c.s_addr;
  assign e_c_sfw.data  = r_c.s_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench for wb_arbiter against a list-based arbitration model.
module tb_wb_arbiter;
  import nand_cpu_pkg::*;
  localparam int N = 4;
  localparam int LIM = 7;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct packed {
    logic dv; logic [D_AW-1:0] da; logic [15:0] dd;
    logic sv; logic [S_AW-1:0] sa; logic sd;
  } port_t;
  typedef struct packed { port_t a; port_t c; } exp_t;
  logic clk = 0, n_rst = 0, flush = 0;
  logic [N-1:0] req_valid, req_ready, dv, sv, sd;
  logic [N-1:0][D_AW-1:0] da;
  logic [N-1:0][15:0] dd;
  logic [N-1:0][S_AW-1:0] sa;
  regfile_d_write_ifc a_d(), c_d();
  regfile_s_write_ifc a_s(), c_s();
  wb_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_d_valid(dv), .req_d_addr(da), .req_d_data(dd),
    .req_s_valid(sv), .req_s_addr(sa), .req_s_data(sd),
    .e_a_dfw(a_d), .e_c_dfw(c_d), .e_a_sfw(a_s), .e_c_sfw(c_s)
  );
  always #5 clk = ~clk;
  exp_t q[$];
  int errors = 0, checks = 0;
  int cnt[N];
  int ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Address/data only matter when the matching valid is set.
  function automatic port_t pack(logic v, logic [D_AW-1:0] a, logic [15:0] d,
                                 logic s, logic [S_AW-1:0] b, logic e);
    return '{dv: v, da: v ? a : '0, dd: v ? d : '0, sv: s, sa: s ? b : '0, sd: s ? e : 1'b0};
  endfunction

  function automatic port_t expect_port(int w);
    if (w < 0) return '0;
    return pack(dv[w], da[w], dd[w], sv[w], sa[w], sd[w]);
  endfunction

  task automatic step();
    int w[$];
    logic [N-1:0] taken, exp_r;
    exp_t e;
    taken = '0;
    exp_r = '0;
    if (!flush) begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && cnt[i] == LIM) begin w.push_back(i); taken[i] = 1'b1; end
      for (int k = 0; k < N; k++) begin
        int i = RR ? (ptr + k) % N : k;
        if (req_valid[i] && !taken[i]) begin w.push_back(i); taken[i] = 1'b1; end
      end
      while (w.size() > 2) void'(w.pop_back());
    end
    foreach (w[j]) exp_r[w[j]] = 1'b1;
    check("ready", 64'(req_ready), 64'(exp_r));
    e.a = expect_port(w.size() > 0 ? w[0] : -1);
    e.c = expect_port(w.size() > 1 ? w[1] : -1);
    q.push_back(e);
    for (int i = 0; i < N; i++)
      cnt[i] = (flush || !req_valid[i] || exp_r[i]) ? 0 : (cnt[i] < LIM ? cnt[i] + 1 : LIM);
    if (w.size() > 0) ptr = (w[w.size()-1] + 1) % N;
  endtask

  always @(posedge clk) begin
    #2;
    if (n_rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("port_a", 64'(pack(a_d.valid, a_d.addr, a_d.data, a_s.valid, a_s.addr, a_s.data)), 64'(e.a));
      check("port_c", 64'(pack(c_d.valid, c_d.addr, c_d.data, c_s.valid, c_s.addr, c_s.data)), 64'(e.c));
    end
  end

  task automatic rnd_data();
    for (int i = 0; i < N; i++) begin
      dv[i] = 1'($urandom); da[i] = D_AW'($urandom); dd[i] = 16'($urandom);
      sv[i] = 1'($urandom); sa[i] = S_AW'($urandom); sd[i] = 1'($urandom);
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic f);
    @(posedge clk);
    #1;
    req_valid = v;
    flush = f;
    rnd_data();
    @(negedge clk);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_a"}, 64'({a_d.valid, a_d.addr, a_d.data, a_s.valid, a_s.addr, a_s.data}), 64'd0);
    check({tag, "_c"}, 64'({c_d.valid, c_d.addr, c_d.data, c_s.valid, c_s.addr, c_s.data}), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    n_rst = 0;
    req_valid = '1;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    foreach (cnt[i]) cnt[i] = 0;
    ptr = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    req_valid = '0;
    n_rst = 1;
  endtask

  initial begin
    foreach (cnt[i]) cnt[i] = 0;
    req_valid = '1;
    rnd_data();
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    req_valid = '0;
    n_rst = 1;
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    dv = 4'b0010; da[1] = D_AW'(5); dd[1] = 16'hBEEF; sv = '0;
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    check("beef_a_d", 64'({a_d.valid, a_d.addr, a_d.data}), 64'({1'b1, D_AW'(5), 16'hBEEF}));
    check("beef_c_v", 64'({c_d.valid, c_s.valid, a_s.valid}), 64'd0);
    req_valid = 4'b0101;
    rnd_data();
    @(negedge clk);
    step();
    cyc(4'b0000, 1'b0);
    cyc(4'b1111, 1'b1);
    repeat (20) cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b1);
    repeat (12) cyc(4'b1000 | 4'($urandom), 1'b0);
    repeat (200) cyc(4'($urandom), ($urandom_range(0, 15) == 0));
    do_reset();
    repeat (200) cyc(($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom), ($urandom_range(0, 15) == 0));
    @(posedge clk);
    #1;
    req_valid = '0;
    flush = 0;
    @(posedge clk);
    #3;
    check("drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
